// File: rtl/input_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg
// Shared definitions for the console push-button front end.
//   debounce_state_t : per-channel debounce FSM states
//   DEFAULT_*        : default clock frequency and stable-time constants
//   cycles_from_us() : converts a stable time in microseconds into clock cycles
// ---------------------------------------------------------------------------
package input_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } debounce_state_t;

  localparam int DEFAULT_CLK_FREQ_HZ = 100_000_000;
  localparam int DEFAULT_DEBOUNCE_US = 10_000;

  // Divide first so the intermediate product stays inside 32 bits for
  // realistic clock rates and debounce times.
  function automatic int cycles_from_us(input int clk_freq_hz, input int debounce_us);
    return (clk_freq_hz / 1_000_000) * debounce_us;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One button channel: two-flop synchronizer followed by a counter-qualified
// debounce FSM. The output level changes only after the synchronized input
// has held the opposite value for DEBOUNCE_CYCLES consecutive evaluations.
// Ports:
//   i_sys_clock : system clock
//   i_reset     : synchronous, active-high reset
//   i_din       : logical (polarity-corrected) asynchronous button input
//   o_level     : debounced level, 1 = pressed (registered)
//   o_busy      : 1 while a change is being qualified (registered)
// ---------------------------------------------------------------------------
module debounce_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic i_sys_clock,
  input  logic i_reset,
  input  logic i_din,
  output logic o_level,
  output logic o_busy
);

  // The counter only ever reaches DEBOUNCE_CYCLES-1, so clog2 bits suffice.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic            r_s1;
  logic            r_s2;
  debounce_state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_level;
  logic            r_busy;

  always_ff @(posedge i_sys_clock) begin
    if (i_reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;

      case (r_state)
        STABLE_LOW: begin
          if (r_s2) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (!r_s2) begin
            // Reversal before qualification: drop back, level untouched.
            r_state <= STABLE_LOW;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HIGH;
            r_level <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        STABLE_HIGH: begin
          if (!r_s2) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        WAIT_LOW: begin
          if (r_s2) begin
            r_state <= STABLE_HIGH;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LOW;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= STABLE_LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_busy  = r_busy;

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Conditions N_BUTTONS raw, bouncing, asynchronous push-button pins into clean
// debounced levels in the sys_clock domain. Polarity is normalised here so
// that a logical 1 always means pressed; each bit then gets its own
// independent debounce_channel.
// Ports:
//   sys_clock : system clock
//   reset     : synchronous, active-high reset
//   btn_raw   : raw button pins (asynchronous)
//   btn_level : debounced level per button, 1 = pressed
//   btn_busy  : 1 while the corresponding channel is qualifying a change
// ---------------------------------------------------------------------------
module button_debouncer
  import input_pkg::*;
#(
  parameter int N_BUTTONS       = 5,
  parameter int CLK_FREQ_HZ     = DEFAULT_CLK_FREQ_HZ,
  parameter int DEBOUNCE_US     = DEFAULT_DEBOUNCE_US,
  parameter int DEBOUNCE_CYCLES = cycles_from_us(CLK_FREQ_HZ, DEBOUNCE_US),
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_busy
);

  // Inversion happens ahead of the first sync flop so the synchronizer's
  // reset value of 0 always represents "released".
  logic [N_BUTTONS-1:0] w_logical;
  assign w_logical = btn_raw ^ {N_BUTTONS{ACTIVE_LOW}};

  generate
    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .i_sys_clock(sys_clock),
        .i_reset    (reset),
        .i_din      (w_logical[gi]),
        .o_level    (btn_level[gi]),
        .o_busy     (btn_busy[gi])
      );
    end
  endgenerate

endmodule
